// File: rtl/sequenciador_imagens.sv
// sequenciador_imagens: streams one 1024-byte frame per start from the selected image ROM bank to the display driver.
module sequenciador_imagens #(
  parameter int N_IDLE       = 1,
  parameter int N_DORMINDO   = 1,
  parameter int N_COMENDO    = 1,
  parameter int N_DANDO_AULA = 1,
  parameter int N_MORTO      = 1,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              habilita,
  input  logic [3:0]        estado,
  input  logic              tick_quadro,
  output logic [2:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dado,
  output logic [7:0]        px_dado,
  output logic              px_valido,
  input  logic              px_pronto,
  output logic              px_ultimo,
  output logic              ocupado
);
  localparam logic [1:0] OCIOSO = 2'd0, LE = 2'd1, ESPERA = 2'd2, ENVIA = 2'd3;
  logic [1:0] fsm;
  logic [2:0] estado_reg, quadro, estado_novo, quadro_prox;
  logic [9:0] byte_idx;
  logic [3:0] n_atual;
  logic       tick_pend, inicio;
  always_comb begin
    estado_novo = (estado > 4'd4) ? 3'd0 : estado[2:0];
    n_atual = (estado_reg == 3'd1) ? 4'(N_DORMINDO) :
              (estado_reg == 3'd2) ? 4'(N_COMENDO) :
              (estado_reg == 3'd3) ? 4'(N_DANDO_AULA) :
              (estado_reg == 3'd4) ? 4'(N_MORTO) : 4'(N_IDLE);
    quadro_prox = ({1'b0, quadro} + 4'd1 >= n_atual) ? 3'd0 : quadro + 3'd1;
    inicio = (fsm == OCIOSO) && habilita;
  end
  assign mem_sel   = estado_reg;
  assign mem_addr  = ADDR_W'({quadro, byte_idx});
  assign px_ultimo = px_valido & (&byte_idx);
  assign ocupado   = fsm != OCIOSO;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= OCIOSO;
      estado_reg <= 3'd0;
      quadro     <= 3'd0;
      byte_idx   <= 10'd0;
      tick_pend  <= 1'b0;
      px_dado    <= 8'd0;
      px_valido  <= 1'b0;
    end else begin
      // a tick coinciding with the frame-start clear is kept for the next frame
      tick_pend <= tick_quadro | (tick_pend & ~inicio);
      case (fsm)
        OCIOSO: if (habilita) begin
          fsm        <= LE;
          estado_reg <= estado_novo;
          quadro     <= (estado_novo != estado_reg) ? 3'd0 : tick_pend ? quadro_prox : quadro;
          byte_idx   <= 10'd0;
        end
        LE: fsm <= ESPERA;
        ESPERA: begin
          px_dado   <= mem_dado;
          px_valido <= 1'b1;
          fsm       <= ENVIA;
        end
        default: if (px_pronto) begin
          px_valido <= 1'b0;
          fsm       <= (&byte_idx) ? OCIOSO : LE;
          byte_idx  <= (&byte_idx) ? byte_idx : byte_idx + 10'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequenciador_imagens.sv
// tb_sequenciador_imagens: directed self-checking bench for sequenciador_imagens with a 3-frame COMENDO bank.
module tb_sequenciador_imagens;
  logic        clk = 0, rst_n = 0, habilita = 0, tick_quadro = 0, px_pronto = 0;
  logic [3:0]  estado = 0;
  logic [7:0]  mem_dado = 0, px_dado;
  logic [2:0]  mem_sel;
  logic [12:0] mem_addr;
  logic        px_valido, px_ultimo, ocupado;
  int          total = 0, bad = 0;
  time         t_first = 0;

  sequenciador_imagens #(.N_COMENDO(3)) dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .estado(estado), .tick_quadro(tick_quadro),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_dado(mem_dado), .px_dado(px_dado),
    .px_valido(px_valido), .px_pronto(px_pronto), .px_ultimo(px_ultimo), .ocupado(ocupado)
  );

  always #5 clk = ~clk;
  // ROM model: one cycle latency, returns the low byte of the address
  always @(posedge clk) mem_dado <= mem_addr[7:0];

  // Collects one frame starting at the current negedge; returns error tallies for the caller to judge.
  task automatic run_frame(input bit bp, input int hook_at, input logic [3:0] hook_est, input logic hook_hab,
                           input int tick1, input int tick2, output int nbytes, output int errs,
                           output logic [12:0] base, output logic [2:0] sel, output time t0);
    bit started = 0, done = 0, f1 = 0, f2 = 0, fh = 0, stalled = 0;
    logic [7:0] held = 0;
    int cyc = 0;
    nbytes = 0; errs = 0; base = 0; sel = 0; t0 = 0;
    while (!done && cyc < 20000) begin
      tick_quadro = 0;
      if (ocupado && !started) begin started = 1; base = mem_addr; sel = mem_sel; end
      if (started && ocupado && (mem_sel !== sel || mem_addr[12:10] !== base[12:10])) errs++;
      if (px_valido) begin
        if (t0 == 0) t0 = $time;
        if (px_dado !== nbytes[7:0]) errs++;
        if (stalled && px_dado !== held) errs++;
        if (px_ultimo !== (nbytes == 1023)) errs++;
      end else if (px_ultimo !== 1'b0) errs++;
      px_pronto = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = px_valido && !px_pronto;
      held = px_dado;
      if (px_valido && px_pronto) begin
        nbytes++;
        if (nbytes == 1024) done = 1;
      end
      if (!fh && hook_at > 0 && nbytes == hook_at) begin fh = 1; estado = hook_est; habilita = hook_hab; end
      if (!f1 && tick1 >= 0 && nbytes == tick1) begin f1 = 1; tick_quadro = 1; end
      if (!f2 && tick2 >= 0 && nbytes == tick2) begin f2 = 1; tick_quadro = 1; end
      cyc++;
      @(negedge clk);
    end
    tick_quadro = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; habilita = 0; estado = 0; px_pronto = 0;
    repeat (3) @(negedge clk);
    total++; if ({px_valido, px_ultimo, ocupado} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {px_valido, px_ultimo, ocupado}); end
    total++; if (px_dado !== 8'd0) begin bad++; $display("FAIL reset_px_dado: got %0d want 0", px_dado); end
    total++; if (mem_addr !== 13'd0 || mem_sel !== 3'd0) begin bad++; $display("FAIL reset_mem: got addr=%0d sel=%0d want 0 0", mem_addr, mem_sel); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int n, e; logic [12:0] b; logic [2:0] s; time t;
    estado = 0; px_pronto = 0; habilita = 1;
    @(negedge clk);
    total++; if (ocupado !== 1 || px_valido !== 0) begin bad++; $display("FAIL latency_le: got ocupado=%b valido=%b want 1 0", ocupado, px_valido); end
    @(negedge clk);
    total++; if (px_valido !== 0) begin bad++; $display("FAIL latency_espera: got valido=%b want 0", px_valido); end
    @(negedge clk);
    total++; if (px_valido !== 1 || px_dado !== 8'd0) begin bad++; $display("FAIL latency_valid: got valido=%b dado=%0d want 1 0", px_valido, px_dado); end
    run_frame(0, -1, 0, 1, -1, -1, n, e, b, s, t);
    t_first = t;
    total++; if (n !== 1024 || e !== 0) begin bad++; $display("FAIL basic_frame: got bytes=%0d errs=%0d want 1024 0", n, e); end
    total++; if (b !== 13'd0 || s !== 3'd0) begin bad++; $display("FAIL basic_addr: got base=%0d sel=%0d want 0 0", b, s); end
  endtask

  task automatic test_back_to_back();
    int n, e; logic [12:0] b; logic [2:0] s; time t;
    run_frame(0, -1, 0, 1, -1, -1, n, e, b, s, t);
    total++; if (t - t_first !== 30730) begin bad++; $display("FAIL frame_period: got %0d want 30730", t - t_first); end
    total++; if (n !== 1024 || e !== 0 || b !== 13'd0) begin bad++; $display("FAIL back_to_back: got bytes=%0d errs=%0d base=%0d want 1024 0 0", n, e, b); end
  endtask

  task automatic test_backpressure();
    int n, e; logic [12:0] b; logic [2:0] s; time t;
    run_frame(1, -1, 0, 1, -1, -1, n, e, b, s, t);
    total++; if (n !== 1024 || e !== 0) begin bad++; $display("FAIL backpressure: got bytes=%0d errs=%0d want 1024 0", n, e); end
    px_pronto = 1;
  endtask

  task automatic test_animation();
    int n, e; logic [12:0] b; logic [2:0] s; time t;
    int exp_base[5] = '{0, 1024, 2048, 0, 1024};
    int t1[5] = '{10, 10, 10, 10, -1};
    int t2[5] = '{-1, -1, -1, 20, -1};
    estado = 2;
    for (int i = 0; i < 5; i++) begin
      run_frame(0, -1, 0, 1, t1[i], t2[i], n, e, b, s, t);
      total++; if (b !== 13'(exp_base[i]) || s !== 3'd2 || n !== 1024 || e !== 0) begin bad++; $display("FAIL anim_frame%0d: got base=%0d sel=%0d bytes=%0d errs=%0d want %0d 2 1024 0", i, b, s, n, e, exp_base[i]); end
    end
    // tick lands on the frame-start edge: this frame keeps 1024, the next one advances
    tick_quadro = 1;
    @(negedge clk);
    tick_quadro = 0;
    run_frame(0, -1, 0, 1, -1, -1, n, e, b, s, t);
    total++; if (b !== 13'd1024 || s !== 3'd2) begin bad++; $display("FAIL tick_collide_now: got base=%0d sel=%0d want 1024 2", b, s); end
    run_frame(0, -1, 0, 1, -1, -1, n, e, b, s, t);
    total++; if (b !== 13'd2048 || s !== 3'd2) begin bad++; $display("FAIL tick_collide_next: got base=%0d sel=%0d want 2048 2", b, s); end
  endtask

  task automatic test_state_change();
    int n, e; logic [12:0] b; logic [2:0] s; time t;
    run_frame(0, 500, 4'd1, 1, -1, -1, n, e, b, s, t);
    total++; if (s !== 3'd2 || b !== 13'd2048 || n !== 1024 || e !== 0) begin bad++; $display("FAIL state_mid_frame: got sel=%0d base=%0d bytes=%0d errs=%0d want 2 2048 1024 0", s, b, n, e); end
    run_frame(0, 200, 4'd9, 1, -1, -1, n, e, b, s, t);
    total++; if (s !== 3'd1 || b !== 13'd0 || e !== 0) begin bad++; $display("FAIL state_new: got sel=%0d base=%0d errs=%0d want 1 0 0", s, b, e); end
    run_frame(0, -1, 0, 1, -1, -1, n, e, b, s, t);
    total++; if (s !== 3'd0 || b !== 13'd0 || e !== 0) begin bad++; $display("FAIL state_invalid: got sel=%0d base=%0d errs=%0d want 0 0 0", s, b, e); end
  endtask

  task automatic test_habilita_drop();
    int n, e, idle_bad = 0; logic [12:0] b; logic [2:0] s; time t;
    run_frame(0, 100, 4'd9, 0, -1, -1, n, e, b, s, t);
    total++; if (n !== 1024 || e !== 0) begin bad++; $display("FAIL hab_drop_frame: got bytes=%0d errs=%0d want 1024 0", n, e); end
    for (int i = 0; i < 6; i++) begin
      if (ocupado !== 0 || px_valido !== 0) idle_bad++;
      @(negedge clk);
    end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL hab_drop_idle: got %0d busy cycles want 0", idle_bad); end
  endtask

  task automatic test_reset_mid();
    int n = 0, cyc = 0, idle_bad = 0, e; logic [12:0] b; logic [2:0] s; time t;
    estado = 2; habilita = 1; px_pronto = 1;
    while (n < 300 && cyc < 2000) begin
      @(negedge clk);
      if (px_valido) n++;
      cyc++;
    end
    total++; if (n !== 300) begin bad++; $display("FAIL reset_mid_reach: got %0d bytes want 300", n); end
    rst_n = 0; habilita = 0;
    #1;
    total++; if ({px_valido, px_ultimo, ocupado, px_dado, mem_addr, mem_sel} !== 0) begin bad++; $display("FAIL reset_async: got valido=%b ocupado=%b dado=%0d addr=%0d sel=%0d want all 0", px_valido, ocupado, px_dado, mem_addr, mem_sel); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ocupado !== 0 || px_valido !== 0) idle_bad++;
    end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL reset_idle: got %0d busy cycles want 0", idle_bad); end
    habilita = 1;
    run_frame(0, 10, 4'd2, 0, -1, -1, n, e, b, s, t);
    total++; if (n !== 1024 || e !== 0 || b !== 13'd0 || s !== 3'd2) begin bad++; $display("FAIL reset_restart: got bytes=%0d errs=%0d base=%0d sel=%0d want 1024 0 0 2", n, e, b, s); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_backpressure();
    test_animation();
    test_state_change();
    test_habilita_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
